ddr_reader: RTL and testbench

Button-triggered DDR read engine: the read-side counterpart of the DDR write demo. On each rising edge of `but0` it programs a read master for one burst from the current address, drains the returned words from the master's user buffer, and shows the low bits of the last word on `led`. It then advances the address so the next press reads the next block. It sits between the board button/LED pins and the control/user ports of the read master on the DDR bridge.

---
 rtl/ddr_reader_if.sv | 36 +++
 rtl/ddr_reader.sv | 108 ++++++++++
 tb/tb_ddr_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_reader_if.sv
// rtl/ddr_reader_if.sv - control and user-buffer port bundle between ddr_reader and the DDR read master
interface ddr_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  master_crtl_fixed_location;
    logic [ADDR_WIDTH-1:0] master_crtl_read_base;
    logic [ADDR_WIDTH-1:0] master_crtl_length;
    logic                  master_crtl_go;
    logic                  master_crtl_done;
    logic                  master_user_read_buffer;
    logic [DATA_WIDTH-1:0] master_user_buffer_output_data;
    logic                  master_user_data_available;

    modport master (
        output master_crtl_fixed_location,
        output master_crtl_read_base,
        output master_crtl_length,
        output master_crtl_go,
        output master_user_read_buffer,
        input  master_crtl_done,
        input  master_user_buffer_output_data,
        input  master_user_data_available
    );

    modport slave (
        input  master_crtl_fixed_location,
        input  master_crtl_read_base,
        input  master_crtl_length,
        input  master_crtl_go,
        input  master_user_read_buffer,
        output master_crtl_done,
        output master_user_buffer_output_data,
        output master_user_data_available
    );
endinterface

// File: rtl/ddr_reader.sv
// rtl/ddr_reader.sv - button-triggered DDR burst reader; optional data check under DDR_READER_CHECK_EN
module ddr_reader #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h10000000,
    parameter int                    LENGTH_BYTES = 16,
    parameter int                    LED_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ddr_reader_if.master         bus,
    input  logic                 but0,
    output logic [LED_WIDTH-1:0] led,
    output logic                 busy,
    output logic                 error
);
    localparam int WORDS = LENGTH_BYTES / (DATA_WIDTH / 8);
    localparam int CNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                r_state;
    logic                  r_but_q;
    logic [CNT_W-1:0]      r_count;
    logic                  r_done_seen;
    logic [ADDR_WIDTH-1:0] r_read_base;
    logic [LED_WIDTH-1:0]  r_led;

    logic w_edge;
    logic w_pop;
    logic w_full;

    assign w_edge = but0 & ~r_but_q;
    // Zero-latency pop: the show-ahead head word is consumed on the same edge it is captured
    assign w_pop  = (r_state == S_DRAIN) && bus.master_user_data_available
                    && (r_count < CNT_W'(WORDS));
    assign w_full = (r_count == CNT_W'(WORDS));

    assign bus.master_crtl_fixed_location = 1'b0;
    assign bus.master_crtl_length         = ADDR_WIDTH'(LENGTH_BYTES);
    assign bus.master_crtl_read_base      = r_read_base;
    assign bus.master_crtl_go             = (r_state == S_ARM);
    assign bus.master_user_read_buffer    = w_pop;
    assign led                            = r_led;
    assign busy                           = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_but_q     <= 1'b0;
            r_count     <= '0;
            r_done_seen <= 1'b0;
            r_read_base <= BASE_ADDR;
            r_led       <= '0;
        end else begin
            r_but_q <= but0;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) r_state <= S_ARM;
                end
                S_ARM: begin
                    r_count     <= '0;
                    r_done_seen <= 1'b0;
                    r_state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        r_count <= r_count + 1'b1;
                        r_led   <= bus.master_user_buffer_output_data[LED_WIDTH-1:0];
                    end
                    if (bus.master_crtl_done) r_done_seen <= 1'b1;
                    // done may precede or follow the last pop; both must have happened
                    if (w_full && (r_done_seen || bus.master_crtl_done)) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_read_base <= r_read_base + ADDR_WIDTH'(LENGTH_BYTES);
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DDR_READER_CHECK_EN
    logic [DATA_WIDTH-1:0] r_expected;
    logic                  r_error;

    // Expected sequence runs on across bursts and restarts only on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected <= '0;
            r_error    <= 1'b0;
        end else if (w_pop) begin
            if (bus.master_user_buffer_output_data != r_expected) r_error <= 1'b1;
            r_expected <= r_expected + 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_reader.sv
// tb/tb_ddr_reader.sv - randomized self-checking bench for ddr_reader against a burst-level model
module tb_ddr_reader;
    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          LW    = 4;
    localparam int          WORDS = 4;
    localparam logic [31:0] BASE  = 32'h10000000;
`ifdef DDR_READER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          but0;
    logic [LW-1:0] led;
    logic          busy;
    logic          error;

    ddr_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ddr_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
        .LENGTH_BYTES(16), .LED_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .but0(but0),
        .led(led), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // burst-level model: cycles since accepted press, pops taken, done seen
    bit          m_valid = 0;
    bit          m_active = 0;
    int          m_age = 0;
    int          m_pops = 0;
    bit          m_dseen = 0;
    bit          m_fin = 0;
    logic [31:0] m_base = BASE;
    logic [3:0]  m_led = 4'h0;
    bit          m_err = 0;
    logic [31:0] m_exp = 0;
    bit          m_but_q = 0;

    // read-master stand-in
    logic [31:0] rm_q[$];
    bit          rm_armed = 0;
    int          rm_age = 0;
    int          rm_popped = 0;
    int          rm_done_after = -1;
    int          rm_avail_start = 1;
    int          rm_gate_mode = 0;
    int          rm_extra = 0;
    bit          rm_inject = 0;
    logic [31:0] rm_next = 0;

    bit          g_reset = 1;
    bit          g_but0 = 0;
    logic        s_busy, s_go, s_rb, s_err, s_fix;
    logic [3:0]  s_led;
    logic [31:0] s_base, s_len;
    int          b_busy, b_go;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        bit          av, gate, dn, press, e_drain, seen_before;
        int          pops_before;
        logic [31:0] d, w;
        @(negedge clk);
        reset = g_reset;
        but0  = g_but0;
        case (rm_gate_mode)
            0:       gate = 1'b1;
            1:       gate = rm_age[0];
            default: gate = 1'($urandom_range(0, 1));
        endcase
        av = rm_armed && (rm_q.size() > 0) && (rm_age >= rm_avail_start) && gate;
        d  = (rm_q.size() > 0) ? rm_q[0] : $urandom();
        if (!rm_armed)               dn = 1'b0;
        else if (rm_done_after >= 0) dn = (rm_age >= rm_done_after);
        else                         dn = (rm_popped + int'(av)) >= WORDS;
        bus.master_user_data_available     = av;
        bus.master_user_buffer_output_data = d;
        bus.master_crtl_done               = dn;
        #1;
        s_busy = busy;
        s_go   = bus.master_crtl_go;
        s_rb   = bus.master_user_read_buffer;
        s_led  = led;
        s_base = bus.master_crtl_read_base;
        s_err  = error;
        s_len  = bus.master_crtl_length;
        s_fix  = bus.master_crtl_fixed_location;
        if (m_valid) begin
            e_drain = m_active && (m_age >= 2) && !m_fin;
            chk("busy", 32'(s_busy), 32'(m_active));
            chk("go", 32'(s_go), 32'(m_active && m_age == 1));
            chk("read_buffer", 32'(s_rb), 32'(e_drain && av && m_pops < WORDS));
            chk("led", 32'(s_led), 32'(m_led));
            chk("read_base", s_base, m_base);
            chk("error", 32'(s_err), 32'(m_err));
        end
        if (s_busy) b_busy++;
        if (s_go)   b_go++;
        @(posedge clk);
        if (g_reset) begin
            m_valid = 1; m_active = 0; m_age = 0; m_pops = 0; m_dseen = 0; m_fin = 0;
            m_base = BASE; m_led = 4'h0; m_err = 0; m_exp = 0; m_but_q = 0;
            rm_q.delete(); rm_armed = 0; rm_age = 0; rm_popped = 0; rm_next = 0;
        end else begin
            press   = g_but0 && !m_but_q;
            m_but_q = g_but0;
            if (!m_active) begin
                if (press) begin
                    m_active = 1; m_age = 1; m_pops = 0; m_dseen = 0; m_fin = 0;
                end
            end else if (m_fin) begin
                m_active = 0; m_fin = 0; m_base = m_base + 32'd16;
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                pops_before = m_pops;
                seen_before = m_dseen;
                if (av && m_pops < WORDS) begin
                    m_pops++;
                    m_led = d[3:0];
                    if (CHK && d !== m_exp) m_err = 1;
                    m_exp = m_exp + 1;
                end
                if (dn) m_dseen = 1;
                if (pops_before == WORDS && (seen_before || dn)) m_fin = 1;
            end
            // the read master follows what the DUT actually drove
            if (s_go) begin
                rm_q.delete();
                for (int k = 0; k < WORDS; k++) begin
                    w = rm_next;
                    rm_next = rm_next + 1;
                    if (rm_inject && k == 2) w = 32'hFF;
                    rm_q.push_back(w);
                end
                for (int k = 0; k < rm_extra; k++) rm_q.push_back($urandom());
                rm_inject = 0; rm_armed = 1; rm_age = 1; rm_popped = 0;
            end else begin
                if (rm_armed) rm_age++;
                if (s_rb && rm_q.size() > 0) begin
                    void'(rm_q.pop_front());
                    rm_popped++;
                end
            end
        end
    endtask

    task automatic burst(input int e1, input int e2, input int budget);
        b_busy = 0;
        b_go   = 0;
        g_but0 = 1;
        step();
        g_but0 = 0;
        for (int i = 0; i < budget && m_active; i++) begin
            g_but0 = (i == e1) || (i == e2);
            step();
        end
        g_but0 = 0;
        chk("burst_completes", 32'(m_active), 32'd0);
    endtask

    task automatic knobs(input int gm, input int da, input int as, input int ex);
        rm_gate_mode = gm; rm_done_after = da; rm_avail_start = as; rm_extra = ex;
    endtask

    initial begin
        int e1;
        bus.master_crtl_done               = 1'b0;
        bus.master_user_data_available     = 1'b0;
        bus.master_user_buffer_output_data = '0;
        reset = 1'b1;
        but0  = 1'b0;

        g_reset = 1; step(); step(); g_reset = 0; step();
        chk("rst_led", 32'(s_led), 32'd0);
        chk("rst_go", 32'(s_go), 32'd0);
        chk("rst_rb", 32'(s_rb), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_base", s_base, 32'h10000000);
        chk("rst_length", s_len, 32'd16);
        chk("rst_fixed", 32'(s_fix), 32'd0);

        knobs(0, -1, 1, 2);
        burst(-1, -1, 50);
        chk("single_go_count", 32'(b_go), 32'd1);
        chk("single_busy_cycles", 32'(b_busy), 32'd7);
        step();
        chk("single_led", 32'(s_led), 32'h3);
        chk("single_next_base", s_base, 32'h10000010);

        knobs(0, 2, 6, 1);
        burst(-1, -1, 50);
        chk("early_done_busy_cycles", 32'(b_busy), 32'd12);
        step();
        chk("early_done_led", 32'(s_led), 32'h7);
        chk("early_done_base", s_base, 32'h10000020);

        knobs(1, -1, 1, 3);
        burst(3, 6, 60);
        chk("gapped_go_count", 32'(b_go), 32'd1);
        step(); step();
        chk("gapped_led", 32'(s_led), 32'hB);
        chk("gapped_base", s_base, 32'h10000030);
        chk("gapped_no_second_burst", 32'(s_busy), 32'd0);

        g_reset = 1; step(); step(); g_reset = 0; step();
        knobs(0, -1, 1, 0);
        rm_inject = 1;
        burst(-1, -1, 50);
        step();
        chk("check_err_after_bad", 32'(s_err), 32'(CHK));
        burst(-1, -1, 50);
        step();
        chk("check_err_sticky", 32'(s_err), 32'(CHK));
        chk("check_led", 32'(s_led), 32'h7);

        for (int b = 0; b < 24; b++) begin
            knobs($urandom_range(0, 2),
                  ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 12),
                  $urandom_range(1, 5), $urandom_range(0, 3));
            rm_inject = ($urandom_range(0, 7) == 0);
            e1 = $urandom_range(0, 5);
            burst(e1, e1 + 2 + $urandom_range(0, 4), 100);
            for (int k = 0; k < $urandom_range(0, 3); k++) step();
        end
        step();
        chk("random_final_base", s_base, m_base);

        g_reset = 1; step(); g_reset = 0;
        knobs(0, -1, 1, 0);
        g_but0 = 1; step(); g_but0 = 0;
        for (int i = 0; i < 20 && m_pops < 2; i++) step();
        chk("midrst_two_pops", 32'(m_pops), 32'd2);
        g_reset = 1; step(); g_reset = 0; step();
        chk("midrst_busy", 32'(s_busy), 32'd0);
        chk("midrst_base", s_base, 32'h10000000);
        chk("midrst_led", 32'(s_led), 32'd0);
        chk("midrst_rb", 32'(s_rb), 32'd0);
        for (int k = 0; k < 3; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
